// File: rtl/tlp_pkg.sv
// Shared constants for the TLP framer: K-codes, fmt/type codes, FSM states,
// and the bit ordering of the one-hot type vector.
package tlp_pkg;

  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;

  localparam logic [2:0] FMT_3DW_ND = 3'b000;
  localparam logic [2:0] FMT_4DW_ND = 3'b001;
  localparam logic [2:0] FMT_3DW_D  = 3'b010;
  localparam logic [2:0] FMT_4DW_D  = 3'b011;

  localparam logic [4:0] TYP_MEM  = 5'b00000;
  localparam logic [4:0] TYP_IO   = 5'b00010;
  localparam logic [4:0] TYP_CFG0 = 5'b00100;
  localparam logic [4:0] TYP_CFG1 = 5'b00101;
  localparam logic [4:0] TYP_CPL  = 5'b01010;

  typedef enum logic [1:0] {IDLE, FRAME, DROP, HOLD} state_t;

  // Type vector ordering: {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}
  localparam int TYPE_W   = 10;
  localparam int T_MRD    = 0;
  localparam int T_MWR    = 1;
  localparam int T_IORD   = 2;
  localparam int T_IOWR   = 3;
  localparam int T_CFGRD0 = 4;
  localparam int T_CFGWR0 = 5;
  localparam int T_CFGRD1 = 6;
  localparam int T_CFGWR1 = 7;
  localparam int T_CPL    = 8;
  localparam int T_CPLD   = 9;

endpackage

// File: rtl/tlp_type_decoder.sv
// Combinational one-hot TLP type decode of header byte 0; zero latency, no flow control.
// Unknown fmt/type combinations decode to all zeros.
module tlp_type_decoder
  import tlp_pkg::*;
(
  input  logic [7:0]        byte0,
  output logic [TYPE_W-1:0] type_vec
);

  logic [2:0] fmt;
  logic [4:0] typ;

  assign fmt = byte0[7:5];
  assign typ = byte0[4:0];

  always_comb begin
    type_vec = '0;
    case (typ)
      TYP_MEM: begin
        // Memory requests are the only types with a legal 4DW form here.
        if (fmt == FMT_3DW_ND || fmt == FMT_4DW_ND) type_vec[T_MRD] = 1'b1;
        else if (fmt == FMT_3DW_D || fmt == FMT_4DW_D) type_vec[T_MWR] = 1'b1;
      end
      TYP_IO: begin
        if (fmt == FMT_3DW_ND) type_vec[T_IORD] = 1'b1;
        else if (fmt == FMT_3DW_D) type_vec[T_IOWR] = 1'b1;
      end
      TYP_CFG0: begin
        if (fmt == FMT_3DW_ND) type_vec[T_CFGRD0] = 1'b1;
        else if (fmt == FMT_3DW_D) type_vec[T_CFGWR0] = 1'b1;
      end
      TYP_CFG1: begin
        if (fmt == FMT_3DW_ND) type_vec[T_CFGRD1] = 1'b1;
        else if (fmt == FMT_3DW_D) type_vec[T_CFGWR1] = 1'b1;
      end
      TYP_CPL: begin
        if (fmt == FMT_3DW_ND) type_vec[T_CPL] = 1'b1;
        else if (fmt == FMT_3DW_D) type_vec[T_CPLD] = 1'b1;
      end
      default: type_vec = '0;
    endcase
  end

endmodule

// File: rtl/tlp_framer.sv
// Frames STP..END byte-stream TLPs; tlp_valid one cycle after K-END, held until tlp_ready.
// Optional TLP_FRAMER_EDB_EN: K-EDB nullifies an open frame without counting an error.
module tlp_framer
  import tlp_pkg::*;
#(
  parameter int MAX_BYTES = 20,
  parameter int MIN_BYTES = 12,
  parameter int CNT_W     = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  input  logic                   data_k,
  input  logic                   tlp_ready,
  output logic                   tlp_valid,
  output logic [8*MAX_BYTES-1:0] TLP,
  output logic [LEN_W-1:0]       tlp_len,
  output logic [CNT_W-1:0]       TLP_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   MRd,
  output logic                   MWr,
  output logic                   IORd,
  output logic                   IOWr,
  output logic                   CfgRd0,
  output logic                   CfgWr0,
  output logic                   CfgRd1,
  output logic                   CfgWr1,
  output logic                   Cpl,
  output logic                   CplD
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_BYTES);

  state_t                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] buf_q;
  logic [LEN_W-1:0]       len_q;
  logic [CNT_W-1:0]       tlp_cnt_q;
  logic [CNT_W-1:0]       err_q;

  logic buf_clr, buf_wr, err_inc, tlp_inc;
  logic is_stp, is_end, is_edb;

  assign is_stp = data_k && (data_in == K_STP);
  assign is_end = data_k && (data_in == K_END);
  assign is_edb = data_k && (data_in == K_EDB);

  always_comb begin
    state_d = state_q;
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    err_inc = 1'b0;
    tlp_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_stp) begin
          buf_clr = 1'b1;
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (!data_k) begin
          if (len_q < MAX_L) begin
            buf_wr = 1'b1;
          end else begin
            err_inc = 1'b1;
            state_d = DROP;
          end
        end else if (is_end) begin
          if (len_q >= MIN_L) begin
            tlp_inc = 1'b1;
            state_d = HOLD;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end else if (is_stp) begin
          err_inc = 1'b1;
          buf_clr = 1'b1;
`ifdef TLP_FRAMER_EDB_EN
        end else if (is_edb) begin
          state_d = IDLE;
`endif
        end else begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (is_end || is_edb) begin
          state_d = IDLE;
        end else if (is_stp) begin
          buf_clr = 1'b1;
          state_d = FRAME;
        end
      end
      HOLD: begin
        // A STP in the release cycle opens the next frame; otherwise it is a collision.
        if (tlp_ready) begin
          if (is_stp) begin
            buf_clr = 1'b1;
            state_d = FRAME;
          end else begin
            state_d = IDLE;
          end
        end else if (is_stp) begin
          err_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      len_q     <= '0;
      tlp_cnt_q <= '0;
      err_q     <= '0;
    end else begin
      state_q <= state_d;
      if (buf_clr) begin
        buf_q <= '0;
        len_q <= '0;
      end else if (buf_wr) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (len_q == LEN_W'(i)) buf_q[8*i +: 8] <= data_in;
        end
        len_q <= len_q + 1'b1;
      end
      if (tlp_inc) tlp_cnt_q <= tlp_cnt_q + 1'b1;
      if (err_inc && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  logic [TYPE_W-1:0] type_raw, type_g;

  tlp_type_decoder u_dec (
    .byte0    (buf_q[7:0]),
    .type_vec (type_raw)
  );

  assign tlp_valid = (state_q == HOLD);
  assign type_g    = tlp_valid ? type_raw : '0;
  assign TLP       = buf_q;
  assign tlp_len   = len_q;
  assign TLP_count = tlp_cnt_q;
  assign err_count = err_q;

  assign MRd    = type_g[T_MRD];
  assign MWr    = type_g[T_MWR];
  assign IORd   = type_g[T_IORD];
  assign IOWr   = type_g[T_IOWR];
  assign CfgRd0 = type_g[T_CFGRD0];
  assign CfgWr0 = type_g[T_CFGWR0];
  assign CfgRd1 = type_g[T_CFGRD1];
  assign CfgWr1 = type_g[T_CFGWR1];
  assign Cpl    = type_g[T_CPL];
  assign CplD   = type_g[T_CPLD];

endmodule

// File: tb/tb_tlp_framer.sv
// Directed bench for tlp_framer: table of whole frames plus hand-written corner sequences.
module tb_tlp_framer;
  import tlp_pkg::*;

  localparam int MAXB = 20;
  localparam int LW   = 5;

  logic             clk, reset, data_k, tlp_ready;
  logic [7:0]       data_in;
  logic             tlp_valid;
  logic [8*MAXB-1:0] TLP;
  logic [LW-1:0]    tlp_len;
  logic [3:0]       TLP_count, err_count;
  logic MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD;
  logic [9:0]       tvec;

  assign tvec = {CplD, Cpl, CfgWr1, CfgRd1, CfgWr0, CfgRd0, IOWr, IORd, MWr, MRd};

  tlp_framer dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_k(data_k), .tlp_ready(tlp_ready),
    .tlp_valid(tlp_valid), .TLP(TLP), .tlp_len(tlp_len), .TLP_count(TLP_count),
    .err_count(err_count), .MRd(MRd), .MWr(MWr), .IORd(IORd), .IOWr(IOWr),
    .CfgRd0(CfgRd0), .CfgWr0(CfgWr0), .CfgRd1(CfgRd1), .CfgWr1(CfgWr1),
    .Cpl(Cpl), .CplD(CplD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] d, input logic k);
    data_in = d;
    data_k  = k;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_val(input int i, input logic [7:0] b0);
    return (i == 0) ? b0 : 8'(i + 16);
  endfunction

  task automatic frame_body(input int n, input logic [7:0] b0);
    step(K_STP, 1'b1);
    for (int i = 0; i < n; i++) step(byte_val(i, b0), 1'b0);
  endtask

  task automatic note_err();
    if (exp_err < 15) exp_err++;
  endtask

  typedef struct {
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] term;
    logic       exp_valid;
    logic [9:0] exp_type;
    int         exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  initial begin
    tv[0]  = '{12, 8'h40, K_END, 1'b1, 10'b0000000010, 0};
    tv[1]  = '{16, 8'h00, K_END, 1'b1, 10'b0000000001, 0};
    tv[2]  = '{8,  8'h00, K_END, 1'b0, 10'b0000000000, 1};
    tv[3]  = '{21, 8'h00, K_END, 1'b0, 10'b0000000000, 1};
    tv[4]  = '{13, 8'h02, K_END, 1'b1, 10'b0000000100, 0};
    tv[5]  = '{12, 8'h42, K_END, 1'b1, 10'b0000001000, 0};
    tv[6]  = '{14, 8'h04, K_END, 1'b1, 10'b0000010000, 0};
    tv[7]  = '{15, 8'h44, K_END, 1'b1, 10'b0000100000, 0};
    tv[8]  = '{12, 8'h05, K_END, 1'b1, 10'b0001000000, 0};
    tv[9]  = '{12, 8'h45, K_END, 1'b1, 10'b0010000000, 0};
    tv[10] = '{20, 8'h0A, K_END, 1'b1, 10'b0100000000, 0};
    tv[11] = '{20, 8'h4A, K_END, 1'b1, 10'b1000000000, 0};
    tv[12] = '{12, 8'h20, K_END, 1'b1, 10'b0000000001, 0};
    tv[13] = '{12, 8'h60, K_END, 1'b1, 10'b0000000010, 0};
    tv[14] = '{12, 8'h1F, K_END, 1'b1, 10'b0000000000, 0};
    tv[15] = '{12, 8'h22, K_END, 1'b1, 10'b0000000000, 0};
    tv[16] = '{11, 8'h00, K_END, 1'b0, 10'b0000000000, 1};
    tv[17] = '{12, 8'h40, 8'hBC, 1'b0, 10'b0000000000, 1};
`ifdef TLP_FRAMER_EDB_EN
    tv[18] = '{14, 8'h40, K_EDB, 1'b0, 10'b0000000000, 0};
`else
    tv[18] = '{14, 8'h40, K_EDB, 1'b0, 10'b0000000000, 1};
`endif
    tv[19] = '{MAXB, 8'h00, K_END, 1'b1, 10'b0000000001, 0};

    reset = 1'b0; data_in = 8'h00; data_k = 1'b0; tlp_ready = 1'b0;
    #3;
    check("rst_vld",  32'(tlp_valid), 32'd0);
    check("rst_tlp",  32'(|TLP),      32'd0);
    check("rst_len",  32'(tlp_len),   32'd0);
    check("rst_cnt",  32'(TLP_count), 32'd0);
    check("rst_err",  32'(err_count), 32'd0);
    check("rst_type", 32'(tvec),      32'd0);
    #9 reset = 1'b1;

    // Idle symbols, including END outside a frame, are ignored.
    step(K_END, 1'b1);
    step(8'h40, 1'b0);
    check("idle_err", 32'(err_count), 32'd0);

    for (int v = 0; v < NV; v++) begin
      tlp_ready = 1'b1;
      frame_body(tv[v].nbytes, tv[v].b0);
      step(tv[v].term, 1'b1);
      if (tv[v].exp_err != 0) note_err();
      if (tv[v].exp_valid) exp_cnt = (exp_cnt + 1) % 16;
      check($sformatf("v%0d_vld", v), 32'(tlp_valid), 32'(tv[v].exp_valid));
      check($sformatf("v%0d_err", v), 32'(err_count), 32'(exp_err));
      check($sformatf("v%0d_cnt", v), 32'(TLP_count), 32'(exp_cnt));
      check($sformatf("v%0d_type", v), 32'(tvec), 32'(tv[v].exp_type));
      if (tv[v].exp_valid) begin
        check($sformatf("v%0d_len", v), 32'(tlp_len), 32'(tv[v].nbytes));
        check($sformatf("v%0d_last", v), 32'(TLP[8*(tv[v].nbytes-1) +: 8]),
              32'(byte_val(tv[v].nbytes - 1, tv[v].b0)));
        if (tv[v].nbytes < MAXB)
          check($sformatf("v%0d_pad", v), 32'(TLP[8*tv[v].nbytes +: 8]), 32'd0);
      end
      step(8'h00, 1'b0);
      check($sformatf("v%0d_drop", v), 32'(tlp_valid), 32'd0);
    end

    // Backpressure: CplD held for 5 cycles with ready low.
    tlp_ready = 1'b0;
    frame_body(20, 8'h4A);
    step(K_END, 1'b1);
    exp_cnt = (exp_cnt + 1) % 16;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_vld", c), 32'(tlp_valid), 32'd1);
      check($sformatf("hold%0d_cpld", c), 32'(CplD), 32'd1);
      check($sformatf("hold%0d_len", c), 32'(tlp_len), 32'd20);
      if (c < 4) step(8'h00, 1'b0);
    end
    tlp_ready = 1'b1;
    step(8'h00, 1'b0);
    check("hold_drop", 32'(tlp_valid), 32'd0);
    check("hold_cnt",  32'(TLP_count), 32'(exp_cnt));

    // STP collides in HOLD, then STP on the ready cycle opens a back-to-back frame.
    tlp_ready = 1'b0;
    frame_body(12, 8'h40);
    step(K_END, 1'b1);
    exp_cnt = (exp_cnt + 1) % 16;
    step(K_STP, 1'b1);
    note_err();
    check("coll_vld", 32'(tlp_valid), 32'd1);
    check("coll_err", 32'(err_count), 32'(exp_err));
    tlp_ready = 1'b1;
    step(K_STP, 1'b1);
    check("b2b_drop", 32'(tlp_valid), 32'd0);
    for (int i = 0; i < 12; i++) step(byte_val(i, 8'h00), 1'b0);
    check("b2b_wait", 32'(tlp_valid), 32'd0);
    step(K_END, 1'b1);
    exp_cnt = (exp_cnt + 1) % 16;
    check("b2b_vld", 32'(tlp_valid), 32'd1);
    check("b2b_mrd", 32'(MRd),       32'd1);
    check("b2b_cnt", 32'(TLP_count), 32'(exp_cnt));
    step(8'h00, 1'b0);

    // STP inside a frame restarts it.
    frame_body(5, 8'h42);
    frame_body(12, 8'h40);
    note_err();
    step(K_END, 1'b1);
    exp_cnt = (exp_cnt + 1) % 16;
    check("rst_frm_vld", 32'(tlp_valid), 32'd1);
    check("rst_frm_len", 32'(tlp_len),   32'd12);
    check("rst_frm_mwr", 32'(MWr),       32'd1);
    check("rst_frm_err", 32'(err_count), 32'(exp_err));
    step(8'h00, 1'b0);

    // 8'hFB with data_k = 0 is payload.
    step(K_STP, 1'b1);
    for (int i = 0; i < 12; i++) step((i == 3) ? 8'hFB : byte_val(i, 8'h40), 1'b0);
    step(K_END, 1'b1);
    exp_cnt = (exp_cnt + 1) % 16;
    check("fbdat_vld", 32'(tlp_valid),   32'd1);
    check("fbdat_b3",  32'(TLP[31:24]),  32'hFB);
    check("fbdat_len", 32'(tlp_len),     32'd12);
    check("fbdat_err", 32'(err_count),   32'(exp_err));

    // Asynchronous reset while holding a TLP.
    tlp_ready = 1'b0;
    step(8'h00, 1'b0);
    frame_body(12, 8'h40);
    step(K_END, 1'b1);
    check("pre_rst_vld", 32'(tlp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_vld",  32'(tlp_valid), 32'd0);
    check("arst_tlp",  32'(|TLP),      32'd0);
    check("arst_len",  32'(tlp_len),   32'd0);
    check("arst_cnt",  32'(TLP_count), 32'd0);
    check("arst_err",  32'(err_count), 32'd0);
    check("arst_type", 32'(tvec),      32'd0);
    #2 reset = 1'b1;
    exp_err = 0;
    exp_cnt = 0;

    // 17 runts: error counter saturates.
    for (int r = 0; r < 17; r++) begin
      frame_body(2, 8'h00);
      step(K_END, 1'b1);
      note_err();
      if (r == 13) check("sat14", 32'(err_count), 32'd14);
    end
    check("sat_err", 32'(err_count), 32'd15);
    check("sat_exp", 32'(err_count), 32'(exp_err));
    check("sat_cnt", 32'(TLP_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tlp_framer.md
# tlp_framer

Parametrised byte-stream TLP framer, successor to the fixed 20-byte detector. It takes one symbol per clock with a K-character qualifier and frames variable-length TLPs between STP and END. Each completed TLP is presented on a valid/ready output with its byte length and a one-hot type decode. Malformed frames are counted, not delivered. It sits between the lane deskew/descramble stage and the transaction-layer receive logic.

## Interface
- MAX_BYTES, 20: capacity in bytes between STP and END, exclusive of both.
- MIN_BYTES, 12: minimum legal length (3DW header).
- CNT_W, 4: width of the TLP and error counters.
- LEN_W, $clog2(MAX_BYTES+1): width of tlp_len (derived, not overridden).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  8  symbol byte.
- data_k  in  1  1 = data_in is a K-character.
- tlp_ready  in  1  downstream accepts the held TLP.
- tlp_valid  out  1  TLP held and stable.
- TLP  out  8*MAX_BYTES  captured bytes; byte i at [8i+7:8i]; unused bytes are 0.
- tlp_len  out  LEN_W  number of valid bytes.
- TLP_count  out  CNT_W  delivered TLPs; wraps.
- err_count  out  CNT_W  framing errors; saturates at all-ones.
- MRd, MWr, IORd, IOWr, CfgRd0, CfgWr0, CfgRd1, CfgWr1, Cpl, CplD  out  1 each  one-hot type; all 0 unless tlp_valid.

## Operation
- K-codes: STP = 8'hFB, END = 8'hFD, EDB = 8'hFE. They are recognised only with data_k = 1. With data_k = 0, these values are ordinary data.
- IDLE: on K-STP, clear the buffer and len, then go to FRAME. All other symbols are ignored.
- FRAME, data byte with len < MAX_BYTES: store at index len, then len++.
- FRAME, data byte with len == MAX_BYTES: err++, go to DROP.
- FRAME, K-END with len >= MIN_BYTES: go to HOLD, TLP_count++.
- FRAME, K-END with len < MIN_BYTES (runt): err++, go to IDLE.
- FRAME, K-STP: err++, restart the frame (len = 0, buffer cleared), stay in FRAME.
- FRAME, any other K-char (including EDB when the macro is off): err++, go to IDLE.
- DROP: discard symbols until K-END/K-EDB (go to IDLE) or K-STP (go to FRAME, fresh frame). No further err increments.
- HOLD:
  - tlp_valid = 1; TLP, tlp_len and type stay stable.
  - tlp_ready = 1 exits HOLD. If K-STP arrives in the same cycle, go to FRAME; otherwise go to IDLE.
  - K-STP without tlp_ready: err++, the symbol is discarded, and the block stays in HOLD.
- Type decode uses byte 0, with fmt = [7:5] and type = [4:0]:
  - MRd: fmt 000/001, type 00000. MWr: fmt 010/011, type 00000.
  - IORd: 000/00010. IOWr: 010/00010.
  - CfgRd0: 000/00100. CfgWr0: 010/00100.
  - CfgRd1: 000/00101. CfgWr1: 010/00101.
  - Cpl: 000/01010. CplD: 010/01010.
  - Any other code drives all type outputs to 0 while tlp_valid = 1.
- Both counters increment by at most 1 per cycle. At most one error event is possible per cycle.

## Timing
- Reset (asynchronous): state IDLE, buffer 0, len 0, tlp_valid 0, TLP 0, tlp_len 0, counters 0, all type outputs 0.
- Latency: K-END sampled in cycle n gives tlp_valid = 1 and TLP_count incremented in cycle n+1.
- Handshake: the transfer completes on the edge where tlp_valid & tlp_ready. tlp_valid drops in the following cycle unless a K-STP was accepted in that same cycle (FRAME; valid still drops).
- Minimum spacing: an STP accepted on the ready cycle yields the next tlp_valid MIN_BYTES+2 cycles later at best.
- Reset asserted mid-frame or in HOLD discards the TLP without counting.

## Configuration
- TLP_FRAMER_EDB_EN defined:
  - K-EDB in FRAME nullifies the frame: go to IDLE with no err or TLP increment.
  - K-EDB in DROP also ends the drop.
- Undefined: K-EDB in FRAME is an unknown K-char (err++, go to IDLE). DROP still ends on K-EDB.

## Structure
- Package tlp_pkg holds:
  - the STP/END/EDB localparams;
  - the fmt/type code constants;
  - the state enum (IDLE, FRAME, DROP, HOLD);
  - the 10-bit type-vector bit ordering {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}.
- Sub-module tlp_type_decoder: combinational, byte 0 in, 10-bit one-hot out; gated by tlp_valid in the parent.

## Test plan
- K-STP, 12 data bytes (byte0 = 8'h40), K-END, ready held 1 -> tlp_valid one cycle, tlp_len = 12, MWr = 1, TLP_count = 1.
- K-STP, 20 bytes (byte0 = 8'h4A), K-END, ready low for 5 cycles -> valid and CplD held stable 5 cycles, drops after ready, TLP_count = 1.
- K-STP, 21 data bytes, K-END -> err_count = 1, no tlp_valid; a following good 16-byte frame with byte0 = 8'h00 delivers MRd, tlp_len = 16.
- K-STP, 8 bytes, K-END -> runt, err_count = 1. K-STP, 5 bytes, K-STP, 12 bytes, K-END -> err_count = 2, one TLP of length 12.
- K-STP, 14 bytes, K-EDB -> macro on: no error, no TLP; macro off: err_count = 1. Data byte 8'hFB with data_k = 0 inside a frame is stored as data.
- Reset asserted in HOLD -> all outputs 0 immediately. 17 runts in a row -> err_count saturates at 15.
